// File: rtl/cu_pkg.sv
// Shared opcode, step and control-word definitions for the control unit.
// The optional single-step feature (CU_SINGLE_STEP_EN) lives in control_unit.sv.
package cu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LD  = 4'h2,
    OP_ST  = 4'h3,
    OP_ALU = 4'h4,
    OP_JMP = 4'h5,
    OP_JN  = 4'h6,
    OP_JZ  = 4'h7,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam logic [7:0] CU_RESET_PC = 8'h00;

  typedef struct packed {
    logic       pcOE;
    logic       aluOE;
    logic       aluSub;
    logic       aluShiftLeft;
    logic       aluBWr;
    logic [1:0] aluOp;
    logic       regWr0;
    logic       regWr1;
    logic       regBusSel;
    logic       regBusEn;
    logic       aluSel;
    logic       ramAddressEn;
    logic       ramWriteEn;
    logic       ramReadDataSelect;
    logic       ramOE;
  } ctrl_word_t;

  // Opcodes that continue past T1; everything else (NOP and unused codes) ends at T1.
  function automatic logic op_has_exec(input logic [3:0] op);
    return (op >= 4'h1) && (op <= 4'h7);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus and strobe bundle between the control unit (master) and the datapath (slave).
interface control_unit_if;
  logic [7:0] i_bus;
  logic       i_aluFlagN;
  logic       i_aluFlagZ;
  logic [7:0] o_pc;
  logic       o_pcOE;
  logic       o_ctrlAluOE;
  logic       o_ctrlAluSub;
  logic       o_ctrlAluShiftLeft;
  logic       o_ctrlAluBWr;
  logic [1:0] o_ctrlAluOp;
  logic       o_ctrlRegWr0;
  logic       o_ctrlRegWr1;
  logic       o_ctrlRegBusSel;
  logic       o_ctrlRegBusEn;
  logic       o_ctrlAluSel;
  logic       o_ctrlRamAddressEn;
  logic       o_ctrlRamWriteEn;
  logic       o_ctrlRamReadDataSelect;
  logic       o_ctrlRamOE;
  logic       o_halted;
  logic [7:0] o_ir;
  logic [2:0] o_step;

  modport master (
    input  i_bus, i_aluFlagN, i_aluFlagZ,
    output o_pc, o_pcOE, o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft, o_ctrlAluBWr,
           o_ctrlAluOp, o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn,
           o_ctrlAluSel, o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect,
           o_ctrlRamOE, o_halted, o_ir, o_step
  );

  modport slave (
    output i_bus, i_aluFlagN, i_aluFlagZ,
    input  o_pc, o_pcOE, o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft, o_ctrlAluBWr,
           o_ctrlAluOp, o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn,
           o_ctrlAluSel, o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect,
           o_ctrlRamOE, o_halted, o_ir, o_step
  );
endinterface

// File: rtl/cu_decode.sv
// Combinational microcode: maps (IR, step, latched flags) to the control word
// and the register-update enables used by control_unit.
module cu_decode
  import cu_pkg::*;
(
  input  logic [7:0] i_ir,
  input  logic [2:0] i_step,
  input  logic       i_flagN,
  input  logic       i_flagZ,
  output ctrl_word_t o_ctrl,
  output logic       o_pcInc,
  output logic       o_pcLoad,
  output logic       o_irLoad,
  output logic       o_flagLoad,
  output logic       o_done
);

  opcode_e w_op;
  assign w_op = opcode_e'(i_ir[7:4]);

  always_comb begin
    o_ctrl     = '0;
    o_pcInc    = 1'b0;
    o_pcLoad   = 1'b0;
    o_irLoad   = 1'b0;
    o_flagLoad = 1'b0;
    o_done     = 1'b0;
    case (i_step)
      T0: begin
        o_ctrl.pcOE         = 1'b1;
        o_ctrl.ramAddressEn = 1'b1;
      end
      // Opcode is still on the bus here, so the T1 exit decision is made by the caller.
      T1: begin
        o_ctrl.ramOE = 1'b1;
        o_irLoad     = 1'b1;
        o_pcInc      = 1'b1;
      end
      T2: begin
        case (w_op)
          OP_ALU: begin
            o_ctrl.regBusEn  = 1'b1;
            o_ctrl.regBusSel = ~i_ir[3];
            o_ctrl.aluBWr    = 1'b1;
          end
          OP_LDI, OP_LD, OP_ST, OP_JMP, OP_JN, OP_JZ: begin
            o_ctrl.pcOE         = 1'b1;
            o_ctrl.ramAddressEn = 1'b1;
          end
          default: o_done = 1'b1;
        endcase
      end
      T3: begin
        case (w_op)
          OP_LDI: begin
            o_ctrl.ramOE  = 1'b1;
            o_ctrl.regWr0 = ~i_ir[0];
            o_ctrl.regWr1 = i_ir[0];
            o_pcInc       = 1'b1;
            o_done        = 1'b1;
          end
          OP_LD, OP_ST: begin
            o_ctrl.ramOE        = 1'b1;
            o_ctrl.ramAddressEn = 1'b1;
            o_pcInc             = 1'b1;
          end
          OP_ALU: begin
            o_ctrl.aluOE        = 1'b1;
            o_ctrl.aluSel       = i_ir[3];
            o_ctrl.aluOp        = i_ir[1:0];
            o_ctrl.aluSub       = i_ir[2];
            o_ctrl.aluShiftLeft = i_ir[2];
            o_ctrl.regWr0       = ~i_ir[3];
            o_ctrl.regWr1       = i_ir[3];
            o_flagLoad          = 1'b1;
            o_done              = 1'b1;
          end
          OP_JMP: begin
            o_ctrl.ramOE = 1'b1;
            o_pcLoad     = 1'b1;
            o_done       = 1'b1;
          end
          OP_JN: begin
            o_ctrl.ramOE = 1'b1;
            o_pcLoad     = i_flagN;
            o_pcInc      = ~i_flagN;
            o_done       = 1'b1;
          end
          OP_JZ: begin
            o_ctrl.ramOE = 1'b1;
            o_pcLoad     = i_flagZ;
            o_pcInc      = ~i_flagZ;
            o_done       = 1'b1;
          end
          default: o_done = 1'b1;
        endcase
      end
      T4: begin
        o_done = 1'b1;
        case (w_op)
          OP_LD: begin
            o_ctrl.ramOE  = 1'b1;
            o_ctrl.regWr0 = ~i_ir[0];
            o_ctrl.regWr1 = i_ir[0];
          end
          OP_ST: begin
            o_ctrl.regBusEn   = 1'b1;
            o_ctrl.regBusSel  = i_ir[0];
            o_ctrl.ramWriteEn = 1'b1;
          end
          default: ;
        endcase
      end
      default: o_done = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microcoded sequencer for the 8-bit datapath: holds PC, IR, step, flags and halt.
// Define CU_SINGLE_STEP_EN to add i_stepReq, which gates every step on a request edge.
module control_unit
  import cu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = CU_RESET_PC
) (
  input  logic i_clk,
  input  logic i_reset,
`ifdef CU_SINGLE_STEP_EN
  input  logic i_stepReq,
`endif
  control_unit_if.master cu
);

  logic [7:0] r_pc, r_ir;
  logic [2:0] r_step;
  logic       r_flagN, r_flagZ, r_halted;

  logic [7:0] w_pcNext, w_irNext;
  logic [2:0] w_stepNext;
  logic       w_flagNNext, w_flagZNext, w_haltedNext;

  ctrl_word_t w_ctrl, w_ctrlOut;
  logic       w_pcInc, w_pcLoad, w_irLoad, w_flagLoad, w_done;
  logic       w_advance, w_outEn;

`ifdef CU_SINGLE_STEP_EN
  logic [1:0] r_stepSync;
  logic       r_stepPrev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stepSync <= 2'b00;
      r_stepPrev <= 1'b0;
    end else begin
      r_stepSync <= {r_stepSync[0], i_stepReq};
      r_stepPrev <= r_stepSync[1];
    end
  end

  assign w_advance = r_stepSync[1] & ~r_stepPrev;
`else
  assign w_advance = 1'b1;
`endif

  cu_decode u_decode (
    .i_ir       (r_ir),
    .i_step     (r_step),
    .i_flagN    (r_flagN),
    .i_flagZ    (r_flagZ),
    .o_ctrl     (w_ctrl),
    .o_pcInc    (w_pcInc),
    .o_pcLoad   (w_pcLoad),
    .o_irLoad   (w_irLoad),
    .o_flagLoad (w_flagLoad),
    .o_done     (w_done)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= 8'h00;
      r_step   <= T0;
      r_flagN  <= 1'b0;
      r_flagZ  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_pc     <= w_pcNext;
      r_ir     <= w_irNext;
      r_step   <= w_stepNext;
      r_flagN  <= w_flagNNext;
      r_flagZ  <= w_flagZNext;
      r_halted <= w_haltedNext;
    end
  end

  always_comb begin
    w_pcNext     = r_pc;
    w_irNext     = r_ir;
    w_stepNext   = r_step;
    w_flagNNext  = r_flagN;
    w_flagZNext  = r_flagZ;
    w_haltedNext = r_halted;
    if (w_advance && !r_halted) begin
      if (w_irLoad) w_irNext = cu.i_bus;
      if (w_pcLoad) w_pcNext = cu.i_bus;
      else if (w_pcInc) w_pcNext = r_pc + 8'd1;
      if (w_flagLoad) begin
        w_flagNNext = cu.i_aluFlagN;
        w_flagZNext = cu.i_aluFlagZ;
      end
      // The fetched opcode decides at T1 whether to halt, execute, or start the next fetch.
      if (r_step == T1) begin
        if (cu.i_bus[7:4] == OP_HLT) w_haltedNext = 1'b1;
        else if (op_has_exec(cu.i_bus[7:4])) w_stepNext = T2;
        else w_stepNext = T0;
      end else if (w_done) begin
        w_stepNext = T0;
      end else begin
        w_stepNext = r_step + 3'd1;
      end
    end
  end

  assign w_outEn = ~i_reset & ~r_halted & w_advance;

  always_comb begin
    w_ctrlOut = '0;
    if (w_outEn) w_ctrlOut = w_ctrl;
  end

  assign cu.o_pc                    = r_pc;
  assign cu.o_ir                    = r_ir;
  assign cu.o_step                  = r_step;
  assign cu.o_halted                = r_halted;
  assign cu.o_pcOE                  = w_ctrlOut.pcOE;
  assign cu.o_ctrlAluOE             = w_ctrlOut.aluOE;
  assign cu.o_ctrlAluSub            = w_ctrlOut.aluSub;
  assign cu.o_ctrlAluShiftLeft      = w_ctrlOut.aluShiftLeft;
  assign cu.o_ctrlAluBWr            = w_ctrlOut.aluBWr;
  assign cu.o_ctrlAluOp             = w_ctrlOut.aluOp;
  assign cu.o_ctrlRegWr0            = w_ctrlOut.regWr0;
  assign cu.o_ctrlRegWr1            = w_ctrlOut.regWr1;
  assign cu.o_ctrlRegBusSel         = w_ctrlOut.regBusSel;
  assign cu.o_ctrlRegBusEn          = w_ctrlOut.regBusEn;
  assign cu.o_ctrlAluSel            = w_ctrlOut.aluSel;
  assign cu.o_ctrlRamAddressEn      = w_ctrlOut.ramAddressEn;
  assign cu.o_ctrlRamWriteEn        = w_ctrlOut.ramWriteEn;
  assign cu.o_ctrlRamReadDataSelect = w_ctrlOut.ramReadDataSelect;
  assign cu.o_ctrlRamOE             = w_ctrlOut.ramOE;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: a small behavioural datapath (RAM, two regs, ALU) around control_unit,
// running short programs and comparing PC/regs/strobes against hand-computed values.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  control_unit_if cu_if ();

`ifdef CU_SINGLE_STEP_EN
  logic step_req = 1'b0;
`endif

  control_unit #(.RESET_PC(8'h00)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
`ifdef CU_SINGLE_STEP_EN
    .i_stepReq (step_req),
`endif
    .cu        (cu_if)
  );

  // Datapath model: program image in rom, stored bytes overlay it via wram/wvalid.
  logic [7:0] rom    [256];
  logic [7:0] wram   [256];
  logic       wvalid [256];
  logic [7:0] reg0, reg1, alu_b, addr;
  logic [7:0] alu_a, alu_res, ram_rd;

  always_comb alu_a   = cu_if.o_ctrlAluSel ? reg1 : reg0;
  always_comb alu_res = cu_if.o_ctrlAluSub ? (alu_a - alu_b) : (alu_a + alu_b);
  always_comb ram_rd  = wvalid[addr] ? wram[addr] : rom[addr];

  always_comb begin
    cu_if.i_bus = 8'h00;
    if (cu_if.o_pcOE)               cu_if.i_bus = cu_if.o_pc;
    else if (cu_if.o_ctrlRamOE)     cu_if.i_bus = ram_rd;
    else if (cu_if.o_ctrlRegBusEn)  cu_if.i_bus = cu_if.o_ctrlRegBusSel ? reg1 : reg0;
    else if (cu_if.o_ctrlAluOE)     cu_if.i_bus = alu_res;
  end

  assign cu_if.i_aluFlagN = alu_res[7];
  assign cu_if.i_aluFlagZ = (alu_res == 8'h00);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) wvalid[i] <= 1'b0;
    end else begin
      if (cu_if.o_ctrlRamAddressEn) addr <= cu_if.i_bus;
      if (cu_if.o_ctrlRamWriteEn) begin
        wram[addr]   <= cu_if.i_bus;
        wvalid[addr] <= 1'b1;
      end
      if (cu_if.o_ctrlRegWr0) reg0  <= cu_if.i_bus;
      if (cu_if.o_ctrlRegWr1) reg1  <= cu_if.i_bus;
      if (cu_if.o_ctrlAluBWr) alu_b <= cu_if.i_bus;
    end
  end

  logic [15:0] strobes;
  assign strobes = {cu_if.o_pcOE, cu_if.o_ctrlAluOE, cu_if.o_ctrlAluSub, cu_if.o_ctrlAluShiftLeft,
                    cu_if.o_ctrlAluBWr, cu_if.o_ctrlAluOp, cu_if.o_ctrlRegWr0, cu_if.o_ctrlRegWr1,
                    cu_if.o_ctrlRegBusSel, cu_if.o_ctrlRegBusEn, cu_if.o_ctrlAluSel,
                    cu_if.o_ctrlRamAddressEn, cu_if.o_ctrlRamWriteEn,
                    cu_if.o_ctrlRamReadDataSelect, cu_if.o_ctrlRamOE};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("vec %0d %s = %0h ok", vectors, tag, obs);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clear_rom();
    #1 rst = 1'b1;
    #2;
    check("rst_pc", cu_if.o_pc, 8'h00);
    check("rst_step", cu_if.o_step, 3'd0);
    check("rst_ir", cu_if.o_ir, 8'h00);
    check("rst_halted", cu_if.o_halted, 1'b0);
    check("rst_strobes", strobes, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1 check("t0_strobes", strobes, 16'h8008);

    // Two LDIs.
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h5A; rom[8'h02] = 8'h11; rom[8'h03] = 8'hC3;
    do_reset();
    run(8);
    check("ldi_reg0", reg0, 8'h5A);
    check("ldi_reg1", reg1, 8'hC3);
    check("ldi_pc", cu_if.o_pc, 8'h04);
    check("ldi_step", cu_if.o_step, 3'd0);

    // ALU op 4D: reg1 <= reg1 - reg0.
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h03; rom[8'h02] = 8'h11; rom[8'h03] = 8'h05;
    rom[8'h04] = 8'h4D;
    do_reset();
    run(10);
    check("alu_t2_step", cu_if.o_step, 3'd2);
    check("alu_t2_strobes", strobes, 16'h0820);
    run(1);
    check("alu_t3_ir", cu_if.o_ir, 8'h4D);
    check("alu_t3_strobes", strobes, 16'h7290);
    run(1);
    check("alu_result", reg1, 8'h02);
    check("alu_pc", cu_if.o_pc, 8'h05);

    // Z=1: JZ taken, JN not taken, then JMP.
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h05; rom[8'h02] = 8'h11; rom[8'h03] = 8'h05;
    rom[8'h04] = 8'h4D; rom[8'h05] = 8'h70; rom[8'h06] = 8'h20;
    rom[8'h20] = 8'h60; rom[8'h21] = 8'h40; rom[8'h22] = 8'h50; rom[8'h23] = 8'h80;
    do_reset();
    run(16);
    check("jz_taken_pc", cu_if.o_pc, 8'h20);
    run(4);
    check("jn_not_taken_pc", cu_if.o_pc, 8'h22);
    run(4);
    check("jmp_pc", cu_if.o_pc, 8'h80);

    // N=1: JN taken, JZ not taken.
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'h05; rom[8'h02] = 8'h11; rom[8'h03] = 8'h03;
    rom[8'h04] = 8'h4D; rom[8'h05] = 8'h60; rom[8'h06] = 8'h30;
    rom[8'h30] = 8'h70; rom[8'h31] = 8'h50;
    do_reset();
    run(16);
    check("jn_taken_pc", cu_if.o_pc, 8'h30);
    run(4);
    check("jz_not_taken_pc", cu_if.o_pc, 8'h32);

    // ST then LD through the same address.
    clear_rom();
    rom[8'h00] = 8'h10; rom[8'h01] = 8'hAA; rom[8'h02] = 8'h30; rom[8'h03] = 8'hF0;
    rom[8'h04] = 8'h21; rom[8'h05] = 8'hF0;
    do_reset();
    run(9);
    check("st_ram", wram[8'hF0], 8'hAA);
    check("st_pc", cu_if.o_pc, 8'h04);
    run(5);
    check("ld_reg1", reg1, 8'hAA);
    check("ld_pc", cu_if.o_pc, 8'h06);

    // Reset in the middle of LD T3.
    do_reset();
    run(12);
    check("ld_t3_step", cu_if.o_step, 3'd3);
    #2 rst = 1'b1;
    #1;
    check("midrst_pc", cu_if.o_pc, 8'h00);
    check("midrst_step", cu_if.o_step, 3'd0);
    check("midrst_strobes", strobes, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    run(2);
    check("refetch_ir", cu_if.o_ir, 8'h10);
    check("refetch_pc", cu_if.o_pc, 8'h01);

    // NOP at FF wraps PC.
    clear_rom();
    rom[8'h00] = 8'h50; rom[8'h01] = 8'hFF; rom[8'hFF] = 8'h00;
    do_reset();
    run(4);
    check("wrap_jmp_pc", cu_if.o_pc, 8'hFF);
    run(2);
    check("wrap_nop_pc", cu_if.o_pc, 8'h00);

    // LDI at FE takes its operand from FF.
    clear_rom();
    rom[8'h00] = 8'h50; rom[8'h01] = 8'hFE; rom[8'hFE] = 8'h10; rom[8'hFF] = 8'h77;
    do_reset();
    run(8);
    check("wrap_ldi_reg0", reg0, 8'h77);
    check("wrap_ldi_pc", cu_if.o_pc, 8'h00);

    // Unused opcode 9x behaves as a 2-cycle NOP.
    clear_rom();
    rom[8'h00] = 8'h95; rom[8'h01] = 8'h10; rom[8'h02] = 8'h33;
    do_reset();
    run(2);
    check("op9x_step", cu_if.o_step, 3'd0);
    check("op9x_pc", cu_if.o_pc, 8'h01);
    run(4);
    check("op9x_next_reg0", reg0, 8'h33);
    check("op9x_next_pc", cu_if.o_pc, 8'h03);

    // HLT, quiet for 100 cycles, cleared only by reset.
    clear_rom();
    rom[8'h00] = 8'hF0;
    do_reset();
    run(2);
    check("hlt_halted", cu_if.o_halted, 1'b1);
    check("hlt_ir", cu_if.o_ir, 8'hF0);
    check("hlt_pc", cu_if.o_pc, 8'h01);
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        run(1);
        if (strobes !== 16'h0000 || cu_if.o_pc !== 8'h01 || cu_if.o_halted !== 1'b1) bad++;
      end
      check("hlt_quiet_cycles_bad", bad, 0);
    end
    rst = 1'b1;
    #1 check("hlt_cleared", cu_if.o_halted, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Microcoded sequencer directly upstream of the 8-bit datapath (ALU, two-entry regset, RAM with address register, shared bus).
- Fetches instruction bytes over the shared bus, holds the instruction register (IR), program counter (PC), step counter and latched ALU flags.
- Drives every datapath control strobe each cycle, and drives the PC onto the bus during fetch and operand phases.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_bus  in  8  shared datapath bus, sampled for IR, operand and jump target.
- i_aluFlagN  in  1  ALU negative flag, combinational from datapath.
- i_aluFlagZ  in  1  ALU zero flag, combinational from datapath.
- o_pc  out  8  current PC.
- o_pcOE  out  1  PC drives bus.
- o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluShiftLeft, o_ctrlAluBWr  out  1 each  ALU strobes.
- o_ctrlAluOp  out  2  ALU operation.
- o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlAluSel  out  1 each  regset strobes.
- o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect, o_ctrlRamOE  out  1 each  RAM strobes.
- o_halted  out  1  core halted.
- o_ir  out  8  IR, debug visibility.
- o_step  out  3  step counter, debug visibility.

Behaviour:
- Reset (async):
  - PC=RESET_PC; IR, step, flagN and flagZ = 0; halted=0.
  - While i_reset is high, all o_ctrl* and o_pcOE are forced 0 and the bus is released.
- Control outputs are combinational decode of the registered IR, step and flags.
- Exactly one bus driver per step. o_ctrlRamReadDataSelect is always 0 in this revision.
- RAM read data is valid in the cycle RamOE is asserted, using the address latched on an earlier edge.
- Opcode IR[7:4]:
  - 0 NOP
  - 1 LDI d=IR[0]
  - 2 LD d=IR[0]
  - 3 ST s=IR[0]
  - 4 ALU
  - 5 JMP
  - 6 JN
  - 7 JZ
  - F HLT
  - all others execute as NOP.
- ALU field layout: IR[1:0]=aluOp, IR[2]=sub/shiftLeft (both strobes driven from IR[2]), IR[3]=dest d.
- Common steps (all opcodes):
  - T0: pcOE, RamAddressEn.
  - T1: RamOE; IR<=bus; PC<=PC+1.
- Operand fetch (LDI, LD, ST, JMP, JN, JZ):
  - T2: pcOE, RamAddressEn.
- Per-opcode execution:
  - LDI T3: RamOE, RegWr[d], PC+1. Done.
  - LD T3: RamOE, RamAddressEn, PC+1. LD T4: RamOE, RegWr[d]. Done.
  - ST T3: same as LD T3. ST T4: RegBusEn, RegBusSel=s, RamWriteEn. Done.
  - ALU T2: RegBusEn, RegBusSel=!d, AluBWr.
  - ALU T3: AluOE, AluSel=d, aluOp/sub/shift from IR, RegWr[d]; flagN/flagZ <= inputs on this edge. Done.
  - JMP T3: RamOE; PC<=bus.
  - JN T3 / JZ T3: RamOE; PC<=bus if latched flagN / flagZ is 1, else PC+1.
  - HLT at end of T1: halted<=1; step frozen; all strobes 0. Only reset clears halted.
- Cycle counts: NOP 2, LDI 4, ALU 4, JMP/JN/JZ 4, LD 5, ST 5.
- Step counter returns to 0 after the final step; the next fetch starts the next cycle.
- PC wraps 8'hFF -> 8'h00, both on increment and on operand fetch.
- Flags change only in ALU T3; jumps test the latched values.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- When defined:
  - Adds input i_stepReq (1 bit) with internal two-flop synchroniser and rising-edge detect.
  - The state machine advances one step per detected edge; otherwise it holds.
  - While holding, all o_ctrl* and o_pcOE are forced 0, so no bus driver and no strobe.
- When undefined: the state machine advances every clock and the port is absent.

Decomposition:
- cu_pkg: opcode enum, step localparams T0-T4, packed control-word struct covering all strobes, RESET_PC default.
- Sub-module cu_decode: purely combinational microcode decode taking IR, step and flags, returning the control word plus pcInc, pcLoad, irLoad, flagLoad and done.
- control_unit holds the registers.

Test Plan:
- Reset mid-instruction (during LD T3) -> PC=00, step=0, all strobes 0 immediately and asynchronously; fetch restarts at 00.
- RAM {10 5A, 11 C3} -> after 8 cycles reg0=5A, reg1=C3, PC=04.
- RAM {10 03, 11 05, 4D} -> ALU T3 asserts AluOE, AluSel=1, RegWr1, aluOp=01, sub=1; latched flags captured from datapath.
- Z=1 then 70 20 -> PC=20 after 4 cycles. Z=0 -> PC = instruction address+2. JN likewise with N.
- PC=FF executing NOP -> PC=00. LDI at FE -> operand from FF, PC=00.
- F0 -> o_halted=1 after T1; strobes stay 0 for 100 cycles; reset clears. Opcode 9x -> 2-cycle NOP.
